// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly datapath.
//   Q, W       : default modulus and coefficient width (Kyber-sized)
//   mode_e     : butterfly flavour carried per beat
//   mod_add    : (a + b) mod q, one conditional subtract
//   mod_sub    : (a - b) mod q, one conditional add
// Both helpers take operands already reduced to [0, q-1].
package ntt_pkg;

  localparam int unsigned Q = 3329;
  localparam int unsigned W = 12;

  typedef enum logic {
    ModeCt = 1'b0,  // Cooley-Tukey, forward transform
    ModeGs = 1'b1   // Gentleman-Sande, inverse transform
  } mode_e;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W:0]   q);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= q) begin
      sum = sum - q;
    end
    return sum[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W:0]   q);
    logic [W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    // Underflow wraps modulo 2^(W+1); adding q lands back in [0, q-1].
    if (a < b) begin
      diff = diff + q;
    end
    return diff[W-1:0];
  endfunction

endpackage

// File: rtl/mod_multiplier.sv
// Combinational modular multiplier: y = (a * b) mod Q.
//   a, b : W-bit operands in [0, Q-1]
//   y    : W-bit reduced product
module mod_multiplier #(
  parameter int unsigned W = 12,
  parameter int unsigned Q = 3329
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  localparam logic [2*W-1:0] QWide = (2*W)'(Q);

  logic [2*W-1:0] prod;

  always_comb begin
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    y    = W'(prod % QWide);
  end

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined NTT butterfly, three register stages with valid/ready flow control.
//   Mode 0 (CT): t = b*w, x = a+t, y = a-t          (all mod Q)
//   Mode 1 (GS): x = a+b, y = (a-b)*w               (all mod Q)
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid/in_ready         : input handshake; in_mode, in_a, in_b, in_w operands
//   out_valid/out_ready       : output handshake; out_x, out_y results
//   occupancy                 : number of valid stages (0-3)
// Both modes feed the single multiplier with (S1 b-lane, S1 w), so S1 holds either the
// raw a/b (CT) or the pre-add/sub results (GS), and S3 either post-add/subs (CT) or
// passes through (GS).
module ntt_butterfly #(
  parameter int unsigned Q = ntt_pkg::Q,
  parameter int unsigned W = ntt_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_w,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic [1:0]   occupancy
);

  localparam logic [W:0] QExt = (W+1)'(Q);

  logic         s1_valid_q, s2_valid_q, s3_valid_q;
  logic         s1_ready, s2_ready, s3_ready;
  logic         s1_mode_q, s2_mode_q;
  logic [W-1:0] s1_a_q, s1_b_q, s1_w_q;
  logic [W-1:0] s2_a_q, s2_p_q;
  logic [W-1:0] s3_x_q, s3_y_q;
  logic [W-1:0] s1_a_d, s1_b_d;
  logic [W-1:0] s3_x_d, s3_y_d;
  logic [W-1:0] prod;

  // A stage may load when it is empty or its contents move on this cycle.
  assign s3_ready = !s3_valid_q || out_ready;
  assign s2_ready = !s2_valid_q || s3_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;

  always_comb begin
    s1_a_d = in_a;
    s1_b_d = in_b;
    if (in_mode == ntt_pkg::ModeGs) begin
      s1_a_d = ntt_pkg::mod_add(in_a, in_b, QExt);
      s1_b_d = ntt_pkg::mod_sub(in_a, in_b, QExt);
    end
  end

  mod_multiplier #(
    .W (W),
    .Q (Q)
  ) u_mod_multiplier (
    .a (s1_b_q),
    .b (s1_w_q),
    .y (prod)
  );

  always_comb begin
    s3_x_d = s2_a_q;
    s3_y_d = s2_p_q;
    if (s2_mode_q == ntt_pkg::ModeCt) begin
      s3_x_d = ntt_pkg::mod_add(s2_a_q, s2_p_q, QExt);
      s3_y_d = ntt_pkg::mod_sub(s2_a_q, s2_p_q, QExt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s2_mode_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_w_q     <= '0;
      s2_a_q     <= '0;
      s2_p_q     <= '0;
      s3_x_q     <= '0;
      s3_y_q     <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= in_valid;
      end
      if (s1_ready && in_valid) begin
        s1_mode_q <= in_mode;
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s1_w_q    <= in_w;
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s2_ready && s1_valid_q) begin
        s2_mode_q <= s1_mode_q;
        s2_a_q    <= s1_a_q;
        s2_p_q    <= prod;
      end
      if (s3_ready) begin
        s3_valid_q <= s2_valid_q;
      end
      if (s3_ready && s2_valid_q) begin
        s3_x_q <= s3_x_d;
        s3_y_q <= s3_y_d;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign out_x     = s3_x_q;
  assign out_y     = s3_y_q;
  assign occupancy = {1'b0, s1_valid_q} + {1'b0, s2_valid_q} + {1'b0, s3_valid_q};

endmodule

// File: tb/tb_ntt_butterfly.sv
// Directed and random-stream bench for ntt_butterfly; results checked against hand-derived
// values and a small arithmetic reference model.
module tb_ntt_butterfly;

  localparam int unsigned Q = 3329;
  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [W-1:0] in_a, in_b, in_w;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x, out_y;
  logic [1:0]   occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } res_t;

  typedef struct packed {
    logic        m;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] w;
    logic [11:0] x;
    logic [11:0] y;
  } vec_t;

  ntt_butterfly #(
    .Q (Q),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input int unsigned a, input int unsigned b,
                       input int unsigned w);
    in_valid = v;
    in_mode  = m;
    in_a     = W'(a);
    in_b     = W'(b);
    in_w     = W'(w);
  endtask

  function automatic res_t model(input logic m, input int unsigned a, input int unsigned b,
                                 input int unsigned w);
    int unsigned t, x, y;
    if (!m) begin
      t = (b * w) % Q;
      x = (a + t) % Q;
      y = (a + Q - t) % Q;
    end else begin
      x = (a + b) % Q;
      y = (((a + Q - b) % Q) * w) % Q;
    end
    return '{x: 12'(x), y: 12'(y)};
  endfunction

  vec_t dir_v[4];
  vec_t bp_v[4];
  res_t sq[$];

  initial begin
    int   k, sent, got, cyc, hi;
    logic fire, acc;
    logic cm;
    int unsigned ca, cb, cw;
    res_t e;

    dir_v[0] = '{m: 1'b0, a: 12'd0,    b: 12'd3328, w: 12'd3328, x: 12'd1,    y: 12'd3328};
    dir_v[1] = '{m: 1'b0, a: 12'd3328, b: 12'd1,    w: 12'd1,    x: 12'd0,    y: 12'd3327};
    dir_v[2] = '{m: 1'b1, a: 12'd5,    b: 12'd10,   w: 12'd1,    x: 12'd15,   y: 12'd3324};
    dir_v[3] = '{m: 1'b1, a: 12'd3328, b: 12'd3328, w: 12'd17,   x: 12'd3327, y: 12'd0};

    bp_v[0] = '{m: 1'b0, a: 12'd10,   b: 12'd20,  w: 12'd30,   x: 12'd610,  y: 12'd2739};
    bp_v[1] = '{m: 1'b0, a: 12'd200,  b: 12'd1,   w: 12'd1000, x: 12'd1200, y: 12'd2529};
    bp_v[2] = '{m: 1'b1, a: 12'd7,    b: 12'd3,   w: 12'd2,    x: 12'd10,   y: 12'd8};
    bp_v[3] = '{m: 1'b1, a: 12'd3000, b: 12'd500, w: 12'd3,    x: 12'd171,  y: 12'd842};

    // Reset state
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0);
    #2;
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst occupancy", 32'(occupancy), 0);
    chk("rst out_x", 32'(out_x), 0);
    chk("rst out_y", 32'(out_y), 0);
    step();
    step();
    rst_n = 1'b1;
    chk("post-rst in_ready", 32'(in_ready), 1);

    // Single beat latency: 100,2,17 -> 134,66
    drive(1'b1, 1'b0, 100, 2, 17);
    step();
    drive(1'b0, 1'b0, 0, 0, 0);
    chk("lat c1 out_valid", 32'(out_valid), 0);
    chk("lat c1 occupancy", 32'(occupancy), 1);
    step();
    chk("lat c2 out_valid", 32'(out_valid), 0);
    step();
    chk("lat c3 out_valid", 32'(out_valid), 1);
    chk("lat out_x", 32'(out_x), 134);
    chk("lat out_y", 32'(out_y), 66);
    step();
    chk("lat c4 out_valid", 32'(out_valid), 0);

    // Back-to-back wrap-around and mode-1 vectors
    k    = 0;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      if (sent < 4) begin
        drive(1'b1, dir_v[sent].m, dir_v[sent].a, dir_v[sent].b, dir_v[sent].w);
        sent++;
      end else begin
        drive(1'b0, 1'b0, 0, 0, 0);
      end
      step();
      if (out_valid && k < 4) begin
        chk($sformatf("dir%0d x", k), 32'(out_x), 32'(dir_v[k].x));
        chk($sformatf("dir%0d y", k), 32'(out_y), 32'(dir_v[k].y));
        k++;
      end
    end
    chk("dir count", k, 4);

    // Backpressure: four beats offered against a stalled consumer
    out_ready = 1'b0;
    sent      = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, bp_v[sent].m, bp_v[sent].a, bp_v[sent].b, bp_v[sent].w);
      fire = in_ready;
      step();
      if (fire) sent++;
    end
    chk("bp accepted", sent, 3);
    chk("bp in_ready", 32'(in_ready), 0);
    chk("bp occupancy", 32'(occupancy), 3);
    chk("bp out_valid", 32'(out_valid), 1);
    chk("bp out_x", 32'(out_x), 610);
    chk("bp out_y", 32'(out_y), 2739);
    step();
    step();
    chk("bp hold out_x", 32'(out_x), 610);
    chk("bp hold out_y", 32'(out_y), 2739);
    chk("bp hold out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready), 1);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && k < 4) begin
        chk($sformatf("bp%0d x", k), 32'(out_x), 32'(bp_v[k].x));
        chk($sformatf("bp%0d y", k), 32'(out_y), 32'(bp_v[k].y));
        k++;
      end
      fire = in_valid && in_ready;
      step();
      if (fire) begin
        sent++;
        if (sent == 4) drive(1'b0, 1'b0, 0, 0, 0);
      end
    end
    chk("bp 4th accepted", sent, 4);
    chk("bp drained", k, 4);

    // Reset with two beats in flight
    drive(1'b1, 1'b0, 100, 2, 17);
    step();
    step();
    drive(1'b0, 1'b0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst occupancy", 32'(occupancy), 0);
    chk("midrst out_x", 32'(out_x), 0);
    chk("midrst out_y", 32'(out_y), 0);
    chk("midrst in_ready", 32'(in_ready), 1);
    step();
    rst_n = 1'b1;
    hi    = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) hi++;
    end
    chk("midrst stale outputs", hi, 0);
    drive(1'b1, 1'b1, 5, 10, 1);
    step();
    drive(1'b0, 1'b0, 0, 0, 0);
    step();
    step();
    chk("postrst out_valid", 32'(out_valid), 1);
    chk("postrst out_x", 32'(out_x), 15);
    chk("postrst out_y", 32'(out_y), 3324);
    step();

    // Random mixed-mode stream with random backpressure
    sent = 0;
    got  = 0;
    cyc  = 0;
    cm   = 1'($urandom_range(1, 0));
    ca   = $urandom_range(Q - 1, 0);
    cb   = $urandom_range(Q - 1, 0);
    cw   = $urandom_range(Q - 1, 0);
    while (got < 1000 && cyc < 20000) begin
      drive((sent < 1000) && ($urandom_range(3, 0) != 0), cm, ca, cb, cw);
      out_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        sq.push_back(model(cm, ca, cb, cw));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (sq.size() == 0) begin
          chk("stream spurious result", 32'(out_valid), 0);
        end else begin
          e = sq.pop_front();
          chk($sformatf("stream%0d x", got), 32'(out_x), 32'(e.x));
          chk($sformatf("stream%0d y", got), 32'(out_y), 32'(e.y));
        end
        got++;
      end
      step();
      cyc++;
      if (acc) begin
        cm = 1'($urandom_range(1, 0));
        ca = $urandom_range(Q - 1, 0);
        cb = $urandom_range(Q - 1, 0);
        cw = $urandom_range(Q - 1, 0);
      end
    end
    chk("stream results", got, 1000);
    chk("stream leftover", 32'(sq.size()), 0);
    drive(1'b0, 1'b0, 0, 0, 0);
    out_ready = 1'b1;
    step();
    step();
    chk("stream end occupancy", 32'(occupancy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
